uart_echo_buffer: RTL and testbench

- Parametrised, buffered successor to the direct receiver-to-transmitter echo path.
- Sits between `uart_receive` and `uart_transmit`:
  - accepts received words on a one-cycle strobe and queues them in a FIFO of `DEPTH` entries;
  - drives the transmitter's send handshake so no byte is lost while the transmitter is busy.
- Adds occupancy reporting, a sticky overflow flag, and optional CR→CRLF expansion.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/uart_echo_buffer.sv | 151 +++++++++++++++
 tb/tb_uart_echo_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo path: echo FSM state encoding,
// ASCII control characters used by the optional CR->CRLF expansion,
// and the baud divider for 115200 baud from a 100 MHz clock.
package uart_pkg;

    // States of the echo buffer's transmit handshake
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND        = 2'd1,
        WAIT_ACCEPT = 2'd2,
        WAIT_DONE   = 2'd3
    } echo_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // 100 MHz / 115200 baud, rounded
    localparam int DIVIDER_115200 = 868;

    // True when a word of the given width should get an LF appended after it
    function automatic logic is_carriage_return(input logic [7:0] word);
        return word == ASCII_CR;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter so that full and
// empty are never ambiguous.  A push while full is accepted only when a
// pop happens in the same cycle; otherwise it is ignored and the caller
// is expected to flag the drop.  The read word is presented
// combinationally at the head so a pop captures it in the same cycle.
import uart_pkg::*;

module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      count;
    logic                  pop_ok;
    logic                  push_ok;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];
    assign level   = count;

    // Storage array; contents need no reset because the pointers and
    // counter decide what is valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy counter: a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered echo path between uart_receive and uart_transmit.  Received
// words are queued in a sync_fifo and handed to the transmitter one at a
// time through a send/ready handshake, so nothing is lost while the
// transmitter is busy.  Words arriving while the FIFO is full (and no pop
// frees a slot that cycle) are dropped and set a sticky overflow flag.
//
// Optional build macro UART_ECHO_CRLF_EN: when defined and DATA_WIDTH is
// 8, every transmitted CR is followed by an inserted LF that does not
// come from the FIFO.  When undefined, words are echoed verbatim.
import uart_pkg::*;

module uart_echo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_ready,
    input  logic                          tx_ready,
    input  logic                          clear_overflow,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_send,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic                          overflow
);

    echo_state_t           state;
    echo_state_t           state_next;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop;

`ifdef UART_ECHO_CRLF_EN
    localparam bit CRLF_ACTIVE = (DATA_WIDTH == 8);
    logic lf_pending;
    logic load_lf;
`endif

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_ready),
        .pop     (fifo_pop),
        .din     (rx_data),
        .dout    (fifo_dout),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A word is lost only when the FIFO is full and nothing leaves it
    assign drop = rx_ready && fifo_full && !fifo_pop;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake sequencing: pop in IDLE, strobe in SEND, then follow the
    // transmitter's ready line down and back up
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        tx_send    = 1'b0;
`ifdef UART_ECHO_CRLF_EN
        load_lf    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty && tx_ready) begin
                    fifo_pop   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                tx_send    = 1'b1;
                state_next = WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
                if (!tx_ready) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
`ifdef UART_ECHO_CRLF_EN
                    if (lf_pending) begin
                        load_lf    = 1'b1;
                        state_next = SEND;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transmit word register, held steady for the whole handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data <= '0;
        end else if (fifo_pop) begin
            tx_data <= fifo_dout;
`ifdef UART_ECHO_CRLF_EN
        end else if (load_lf) begin
            tx_data <= DATA_WIDTH'(ASCII_LF);
`endif
        end
    end

`ifdef UART_ECHO_CRLF_EN
    // Remember that the word just popped was a CR so an LF follows it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lf_pending <= 1'b0;
        end else if (fifo_pop) begin
            lf_pending <= CRLF_ACTIVE && is_carriage_return(8'(fifo_dout));
        end else if (load_lf) begin
            lf_pending <= 1'b0;
        end
    end
`endif

    // Sticky overflow: a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer (DATA_WIDTH=8, DEPTH=16).
// A small transmitter model drops tx_ready for busy_len cycles after each
// tx_send and records every word sent.  The overflow/full behaviour is
// checked from a cycle-by-cycle vector table; the other scenarios are
// hand-written sequences.
module tb_uart_echo_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    typedef struct {
        logic       rx_ready;
        logic [7:0] rx_data;
        logic       clear_ovf;
        logic [4:0] exp_level;
        logic       exp_ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_ready = 1'b0;
    logic          clear_overflow = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_send;
    logic [4:0]    level;
    logic          overflow;

    logic          tx_hold = 1'b0;
    int            busy_len = 5;
    int            busy_cnt = 0;
    logic [7:0]    sent [$];
    logic [7:0]    exp_q [$];
    vec_t          vecs [23];
    int            total = 0;
    int            bad = 0;
    int            peak;

    uart_echo_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .tx_ready       (tx_ready),
        .clear_overflow (clear_overflow),
        .tx_data        (tx_data),
        .tx_send        (tx_send),
        .level          (level),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    assign tx_ready = !tx_hold && (busy_cnt == 0);

    // Transmitter model: record each strobed word and go busy
    always @(negedge clk) begin
        if (tx_send === 1'b1) begin
            sent.push_back(tx_data);
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rx_ready       = v.rx_ready;
        rx_data        = v.rx_data;
        clear_overflow = v.clear_ovf;
    endtask

    // Wait (bounded) for the words in exp_q, let the line settle, then compare
    task automatic check_sends(input string name, input int budget);
        int cyc = 0;
        while (sent.size() < exp_q.size() && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        repeat (busy_len + 10) @(negedge clk);
        check_output({name, " count"}, 32'(sent.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check_output($sformatf("%s word %0d", name, i),
                         (i < sent.size()) ? 32'(sent[i]) : 32'hFFFF_FFFF,
                         32'(exp_q[i]));
        end
        sent.delete();
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Overflow table: transmitter held off, 18 pushes into DEPTH=16
        for (int i = 0; i < 18; i++) begin
            vecs[i] = '{1'b1, 8'(8'h50 + i), 1'b0, 5'((i + 1 > 16) ? 16 : i + 1), (i >= 16)};
        end
        vecs[18] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b0};
        vecs[20] = '{1'b1, 8'h70, 1'b1, 5'd16, 1'b1};
        vecs[21] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b0};
        vecs[22] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check_output("reset tx_send", 32'(tx_send), 0);
        check_output("reset level", 32'(level), 0);
        check_output("reset overflow", 32'(overflow), 0);
        check_output("reset tx_data", 32'(tx_data), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single word: level 0->1->0, strobe two cycles after the push
        $display("[TB] single word");
        rx_data  = 8'h41;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_output("single level +1", 32'(level), 1);
        check_output("single no early send", 32'(tx_send), 0);
        @(negedge clk);
        check_output("single tx_send +2", 32'(tx_send), 1);
        check_output("single tx_data", 32'(tx_data), 32'h41);
        check_output("single level after pop", 32'(level), 0);
        exp_q.push_back(8'h41);
        check_sends("single", 200);

        // Burst of ten words against a slow transmitter
        $display("[TB] burst");
        busy_len = 100;
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (int'(level) > peak) peak = int'(level);
            rx_data  = 8'(8'h30 + i);
            rx_ready = 1'b1;
        end
        @(negedge clk);
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (int'(level) > peak) peak = int'(level);
            @(negedge clk);
        end
        check_output("burst peak 9 or 10", 32'(peak == 9 || peak == 10), 1);
        check_output("burst overflow", 32'(overflow), 0);
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h30 + i));
        check_sends("burst", 3000);

        // Overflow table with the transmitter held off
        $display("[TB] overflow table");
        busy_len = 5;
        tx_hold  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output($sformatf("vec %0d level", i), 32'(level), 32'(vecs[i].exp_level));
            check_output($sformatf("vec %0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check_output($sformatf("vec %0d tx_send", i), 32'(tx_send), 0);
        end
        rx_ready       = 1'b0;
        clear_overflow = 1'b0;

        // Full FIFO: release the transmitter and push in the pop cycle
        @(negedge clk);
        tx_hold  = 1'b0;
        rx_data  = 8'hAA;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_output("full push+pop level", 32'(level), 16);
        check_output("full push+pop overflow", 32'(overflow), 0);
        check_output("full push+pop tx_send", 32'(tx_send), 1);
        check_output("full push+pop tx_data", 32'(tx_data), 32'h50);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h50 + i));
        exp_q.push_back(8'hAA);
        check_sends("drain", 2000);
        check_output("drain level", 32'(level), 0);

        // CR handling
        $display("[TB] carriage return");
        rx_data  = 8'h0D;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_data  = 8'h42;
        @(negedge clk);
        rx_ready = 1'b0;
        exp_q.push_back(8'h0D);
`ifdef UART_ECHO_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        exp_q.push_back(8'h42);
        check_sends("crlf", 500);
        check_output("crlf level", 32'(level), 0);

        // Reset while waiting on the transmitter with five words queued
        $display("[TB] reset mid-operation");
        busy_len = 20;
        for (int i = 0; i < 6; i++) begin
            rx_data  = 8'(8'h60 + i);
            rx_ready = 1'b1;
            @(negedge clk);
        end
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_output("pre-reset level", 32'(level), 5);
        check_output("pre-reset tx_data", 32'(tx_data), 32'h60);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async reset tx_data", 32'(tx_data), 0);
        check_output("async reset tx_send", 32'(tx_send), 0);
        check_output("async reset level", 32'(level), 0);
        check_output("async reset overflow", 32'(overflow), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sent.delete();
        repeat (150) @(negedge clk);
        check_output("no send after reset", 32'(sent.size()), 0);
        check_output("level after reset", 32'(level), 0);
        rx_data  = 8'h77;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        exp_q.push_back(8'h77);
        check_sends("post-reset", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
